// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, 8-byte lines, single outstanding refill.
// Define ICACHE_PERF_EN to add the perf_hits / perf_misses counter outputs.
module icache_direct #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    input  logic        if_flush,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic        mem_instr_signal,
    output logic [31:0] mem_instr_a,
    input  logic [63:0] mem_instr_d,
    input  logic        mem_instr_done
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    localparam int unsigned Lines = 1 << INDEX_BITS;
    localparam int unsigned TagW  = 29 - INDEX_BITS;

    typedef enum logic [0:0] {StIdle, StMiss} state_e;

    state_e                  state_q, state_d;
    logic [Lines-1:0]        line_valid_q;
    logic [TagW-1:0]         tag_mem [Lines];
    logic [63:0]             data_mem [Lines];

    logic                    if_valid_q, if_valid_d;
    logic [31:0]             if_instr_q, if_instr_d;
    logic [31:0]             mem_a_q, mem_a_d;
    logic                    word_sel_q, word_sel_d;
    logic                    drop_q, drop_d;
    logic                    fill_en, acc_hit, acc_miss;

    logic [INDEX_BITS-1:0]   req_idx, fill_idx;
    logic [TagW-1:0]         req_tag, fill_tag;
    logic                    hit;
    logic [31:0]             hit_word, fill_word;
    logic                    unused_pc;

    assign req_idx   = if_pc[2+INDEX_BITS:3];
    assign req_tag   = if_pc[31:3+INDEX_BITS];
    assign fill_idx  = mem_a_q[2+INDEX_BITS:3];
    assign fill_tag  = mem_a_q[31:3+INDEX_BITS];
    assign hit       = line_valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit_word  = if_pc[2] ? data_mem[req_idx][63:32] : data_mem[req_idx][31:0];
    assign fill_word = word_sel_q ? mem_instr_d[63:32] : mem_instr_d[31:0];
    assign unused_pc = ^{if_pc[1:0], mem_a_q[2:0]};

    assign if_ready         = (state_q == StIdle);
    assign if_valid         = if_valid_q;
    assign if_instr         = if_instr_q;
    assign mem_instr_a      = mem_a_q;
    // Combinational drop on done so the controller never sees a second request.
    assign mem_instr_signal = (state_q == StMiss) & ~mem_instr_done;

    always_comb begin
        state_d    = state_q;
        if_valid_d = 1'b0;
        if_instr_d = if_instr_q;
        mem_a_d    = mem_a_q;
        word_sel_d = word_sel_q;
        drop_d     = drop_q;
        fill_en    = 1'b0;
        acc_hit    = 1'b0;
        acc_miss   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (if_req && !if_flush) begin
                    if (hit) begin
                        acc_hit    = 1'b1;
                        if_valid_d = 1'b1;
                        if_instr_d = hit_word;
                    end else begin
                        acc_miss   = 1'b1;
                        state_d    = StMiss;
                        mem_a_d    = {if_pc[31:3], 3'b000};
                        word_sel_d = if_pc[2];
                        drop_d     = 1'b0;
                    end
                end
            end
            StMiss: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_instr_done) begin
                    fill_en = 1'b1;
                    state_d = StIdle;
                    if (!drop_q && !if_flush) begin
                        if_valid_d = 1'b1;
                        if_instr_d = fill_word;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            line_valid_q <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            mem_a_q      <= '0;
            word_sel_q   <= 1'b0;
            drop_q       <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            mem_a_q    <= mem_a_d;
            word_sel_q <= word_sel_d;
            drop_q     <= drop_d;
            if (fill_en) begin
                line_valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset: the valid bits guard every lookup.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_instr_d;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (rdy_in) begin
            if (acc_hit) begin
                hits_q <= hits_q + 32'd1;
            end
            if (acc_miss) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`endif

endmodule
